// File: rtl/id_decode_hazard.sv
// Decode stage: register file with write-through, branch/jump resolution,
// RAW stall detection against a 2-deep destination scoreboard, and ID/EX register.
module id_decode_hazard #(
  parameter logic [5:0] NOP_OP = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_D,
  input  logic [31:0] NPC_D,
  input  logic        WB_we,
  input  logic [3:0]  WB_rd,
  input  logic [31:0] WB_data,
  output logic        disable_PC,
  output logic        disable_IR,
  output logic        KILL,
  output logic [1:0]  PCsrc,
  output logic [31:0] PC_offset,
  output logic [31:0] PC_regRs,
  output logic        EX_valid,
  output logic        EX_we,
  output logic        EX_memrd,
  output logic        EX_memwr,
  output logic [5:0]  EX_op,
  output logic [3:0]  EX_rd,
  output logic [31:0] EX_A,
  output logic [31:0] EX_B,
  output logic [31:0] EX_imm
);

  localparam logic [5:0] OP_AND = 6'd0, OP_ADD = 6'd1, OP_SUB = 6'd2, OP_ADDI = 6'd3,
                         OP_ANDI = 6'd4, OP_LW = 6'd5, OP_SW = 6'd6, OP_BEQ = 6'd7,
                         OP_BNE = 6'd8, OP_J = 6'd9, OP_JR = 6'd10;

  logic [31:0] r_regs [16];
  logic        r_sbex_we, r_sbmem_we;
  logic [3:0]  r_sbex_rd, r_sbmem_rd;

  logic [5:0]  w_op;
  logic [3:0]  w_rd, w_rs, w_rt;
  logic [31:0] w_imm_sext, w_off_sext, w_rs_val, w_rt_val;
  logic        w_nop, w_rd_rs, w_rd_rt, w_writes, w_memrd, w_memwr;
  logic        w_is_beq, w_is_bne, w_is_j, w_is_jr;
  logic        w_we_dec, w_eq, w_stall;

  assign w_op       = Instruction_D[31:26];
  assign w_rd       = Instruction_D[25:22];
  assign w_rs       = Instruction_D[21:18];
  assign w_rt       = Instruction_D[17:14];
  assign w_imm_sext = {{18{Instruction_D[13]}}, Instruction_D[13:0]};
  assign w_off_sext = {{6{Instruction_D[25]}}, Instruction_D[25:0]};

  // A nonzero NOP_OP lets one otherwise-valid opcode be reserved as a no-op.
  assign w_nop = (w_op > OP_JR) || ((NOP_OP != 6'd0) && (w_op == NOP_OP));

  always_comb begin
    w_rd_rs  = 1'b0;
    w_rd_rt  = 1'b0;
    w_writes = 1'b0;
    w_memrd  = 1'b0;
    w_memwr  = 1'b0;
    w_is_beq = 1'b0;
    w_is_bne = 1'b0;
    w_is_j   = 1'b0;
    w_is_jr  = 1'b0;
    if (!w_nop) begin
      case (w_op)
        OP_AND, OP_ADD, OP_SUB: begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_writes = 1'b1; end
        OP_ADDI, OP_ANDI:       begin w_rd_rs = 1'b1; w_writes = 1'b1; end
        OP_LW:                  begin w_rd_rs = 1'b1; w_writes = 1'b1; w_memrd = 1'b1; end
        OP_SW:                  begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_memwr = 1'b1; end
        OP_BEQ:                 begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_is_beq = 1'b1; end
        OP_BNE:                 begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_is_bne = 1'b1; end
        OP_J:                   w_is_j = 1'b1;
        OP_JR:                  begin w_rd_rs = 1'b1; w_is_jr = 1'b1; end
        default:                ;
      endcase
    end
  end

  assign w_we_dec = w_writes && (w_rd != 4'd0);

  // WB write-through: the value being written this cycle is visible to ID now.
  assign w_rs_val = (w_rs == 4'd0) ? 32'd0 :
                    (WB_we && (WB_rd == w_rs)) ? WB_data : r_regs[w_rs];
  assign w_rt_val = (w_rt == 4'd0) ? 32'd0 :
                    (WB_we && (WB_rd == w_rt)) ? WB_data : r_regs[w_rt];
  assign w_eq     = (w_rs_val == w_rt_val);

  function automatic logic sb_hit(input logic [3:0] src, input logic v_ex, input logic [3:0] d_ex,
                                  input logic v_mem, input logic [3:0] d_mem);
    return (src != 4'd0) && ((v_ex && (d_ex == src)) || (v_mem && (d_mem == src)));
  endfunction

  assign w_stall = (w_rd_rs && sb_hit(w_rs, r_sbex_we, r_sbex_rd, r_sbmem_we, r_sbmem_rd)) ||
                   (w_rd_rt && sb_hit(w_rt, r_sbex_we, r_sbex_rd, r_sbmem_we, r_sbmem_rd));

  // Stall wins over redirect so a branch never resolves on stale operands.
  always_comb begin
    disable_PC = 1'b0;
    disable_IR = 1'b0;
    KILL       = 1'b0;
    PCsrc      = 2'b00;
    PC_offset  = 32'd0;
    PC_regRs   = 32'd0;
    if (!reset) begin
      if (w_stall) begin
        disable_PC = 1'b1;
        disable_IR = 1'b1;
      end else if ((w_is_beq && w_eq) || (w_is_bne && !w_eq)) begin
        PCsrc     = 2'b01;
        PC_offset = NPC_D + w_imm_sext;
        KILL      = 1'b1;
      end else if (w_is_j) begin
        PCsrc     = 2'b01;
        PC_offset = NPC_D + w_off_sext;
        KILL      = 1'b1;
      end else if (w_is_jr) begin
        PCsrc    = 2'b10;
        PC_regRs = w_rs_val;
        KILL     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= 32'd0;
      r_sbex_we  <= 1'b0;
      r_sbex_rd  <= 4'd0;
      r_sbmem_we <= 1'b0;
      r_sbmem_rd <= 4'd0;
      EX_valid   <= 1'b0;
      EX_we      <= 1'b0;
      EX_memrd   <= 1'b0;
      EX_memwr   <= 1'b0;
      EX_op      <= 6'd0;
      EX_rd      <= 4'd0;
      EX_A       <= 32'd0;
      EX_B       <= 32'd0;
      EX_imm     <= 32'd0;
    end else begin
      if (WB_we && (WB_rd != 4'd0)) r_regs[WB_rd] <= WB_data;
      r_sbmem_we <= r_sbex_we;
      r_sbmem_rd <= r_sbex_rd;
      if (w_stall) begin
        r_sbex_we <= 1'b0;
        r_sbex_rd <= 4'd0;
        EX_valid  <= 1'b0;
        EX_we     <= 1'b0;
        EX_memrd  <= 1'b0;
        EX_memwr  <= 1'b0;
        EX_op     <= 6'd0;
        EX_rd     <= 4'd0;
        EX_A      <= 32'd0;
        EX_B      <= 32'd0;
        EX_imm    <= 32'd0;
      end else begin
        r_sbex_we <= w_we_dec;
        r_sbex_rd <= w_we_dec ? w_rd : 4'd0;
        EX_valid  <= 1'b1;
        EX_we     <= w_we_dec;
        EX_memrd  <= w_memrd;
        EX_memwr  <= w_memwr;
        EX_op     <= w_op;
        EX_rd     <= w_we_dec ? w_rd : 4'd0;
        EX_A      <= w_rs_val;
        EX_B      <= w_rt_val;
        EX_imm    <= w_imm_sext;
      end
    end
  end

endmodule

// File: tb/tb_id_decode_hazard.sv
// Directed bench for id_decode_hazard: hand-computed expectations checked with
// immediate assertions at each step.
module tb_id_decode_hazard;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction_D;
  logic [31:0] NPC_D;
  logic        WB_we;
  logic [3:0]  WB_rd;
  logic [31:0] WB_data;
  logic        disable_PC, disable_IR, KILL;
  logic [1:0]  PCsrc;
  logic [31:0] PC_offset, PC_regRs;
  logic        EX_valid, EX_we, EX_memrd, EX_memwr;
  logic [5:0]  EX_op;
  logic [3:0]  EX_rd;
  logic [31:0] EX_A, EX_B, EX_imm;

  int n_pass = 0;
  int n_total = 0;

  id_decode_hazard dut (
    .clk(clk), .reset(reset), .Instruction_D(Instruction_D), .NPC_D(NPC_D),
    .WB_we(WB_we), .WB_rd(WB_rd), .WB_data(WB_data),
    .disable_PC(disable_PC), .disable_IR(disable_IR), .KILL(KILL), .PCsrc(PCsrc),
    .PC_offset(PC_offset), .PC_regRs(PC_regRs),
    .EX_valid(EX_valid), .EX_we(EX_we), .EX_memrd(EX_memrd), .EX_memwr(EX_memwr),
    .EX_op(EX_op), .EX_rd(EX_rd), .EX_A(EX_A), .EX_B(EX_B), .EX_imm(EX_imm)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [13:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_ctrl(input string tag, input logic dis, input logic kill,
                          input logic [1:0] src);
    chk({tag, "_disPC"}, 32'(disable_PC), 32'(dis));
    chk({tag, "_disIR"}, 32'(disable_IR), 32'(dis));
    chk({tag, "_kill"},  32'(KILL), 32'(kill));
    chk({tag, "_pcsrc"}, 32'(PCsrc), 32'(src));
  endtask

  task automatic wb(input logic we, input logic [3:0] rd, input logic [31:0] data);
    WB_we = we;
    WB_rd = rd;
    WB_data = data;
  endtask

  initial begin
    // reset with random instruction
    reset = 1'b1;
    Instruction_D = $urandom();
    NPC_D = $urandom();
    wb(1'b0, 4'd0, 32'd0);
    tick();
    chk_ctrl("rst_comb", 1'b0, 1'b0, 2'b00);
    chk("rst_off", PC_offset, 32'd0);
    chk("rst_rrs", PC_regRs, 32'd0);
    Instruction_D = enc(6'd9, 4'd3, 4'd1, 4'd2, 14'h0011);
    tick();
    chk("rst_valid", 32'(EX_valid), 32'd0);
    chk("rst_we", 32'(EX_we), 32'd0);
    chk("rst_op", 32'(EX_op), 32'd0);
    chk("rst_A", EX_A, 32'd0);
    chk("rst_imm", EX_imm, 32'd0);
    chk_ctrl("rst_jcomb", 1'b0, 1'b0, 2'b00);

    // write-through: WB R3=5 with ADD R4,R3,R3 in ID
    reset = 1'b0;
    NPC_D = 32'd100;
    wb(1'b1, 4'd3, 32'd5);
    Instruction_D = enc(6'd1, 4'd4, 4'd3, 4'd3, 14'd0);
    #1;
    chk_ctrl("wt_comb", 1'b0, 1'b0, 2'b00);
    tick();
    chk("wt_A", EX_A, 32'd5);
    chk("wt_B", EX_B, 32'd5);
    chk("wt_rd", 32'(EX_rd), 32'd4);
    chk("wt_we", 32'(EX_we), 32'd1);
    chk("wt_valid", 32'(EX_valid), 32'd1);

    // RAW: ADDI R1,R0,#9 then ADD R2,R1,R1
    wb(1'b0, 4'd0, 32'd0);
    Instruction_D = enc(6'd3, 4'd1, 4'd0, 4'd0, 14'd9);
    #1;
    chk("addi_dis", 32'(disable_PC), 32'd0);
    tick();
    chk("addi_imm", EX_imm, 32'd9);
    chk("addi_rd", 32'(EX_rd), 32'd1);
    Instruction_D = enc(6'd1, 4'd2, 4'd1, 4'd1, 14'd0);
    #1;
    chk_ctrl("raw_s1", 1'b1, 1'b0, 2'b00);
    tick();
    chk("raw_b1_valid", 32'(EX_valid), 32'd0);
    chk("raw_b1_we", 32'(EX_we), 32'd0);
    // an older producer writes R1 while the SB_MEM dependency is pending
    wb(1'b1, 4'd1, 32'd3);
    #1;
    chk_ctrl("raw_s2", 1'b1, 1'b0, 2'b00);
    tick();
    chk("raw_b2_valid", 32'(EX_valid), 32'd0);
    chk("raw_b2_rd", 32'(EX_rd), 32'd0);
    wb(1'b1, 4'd1, 32'd9);
    #1;
    chk_ctrl("raw_go", 1'b0, 1'b0, 2'b00);
    tick();
    chk("raw_valid", 32'(EX_valid), 32'd1);
    chk("raw_A", EX_A, 32'd9);
    chk("raw_B", EX_B, 32'd9);
    chk("raw_rd", 32'(EX_rd), 32'd2);

    // set R1=R2=7 under NOPs
    Instruction_D = 32'd0;
    wb(1'b1, 4'd1, 32'd7);
    tick();
    chk("nop_we", 32'(EX_we), 32'd0);
    wb(1'b1, 4'd2, 32'd7);
    tick();

    // BEQ R1,R2,-4 at NPC 20 -> taken to 16
    wb(1'b0, 4'd0, 32'd0);
    NPC_D = 32'd20;
    Instruction_D = enc(6'd7, 4'd0, 4'd1, 4'd2, 14'h3FFC);
    #1;
    chk_ctrl("beq", 1'b0, 1'b1, 2'b01);
    chk("beq_off", PC_offset, 32'd16);
    chk("beq_rrs", PC_regRs, 32'd0);
    tick();
    chk("beq_valid", 32'(EX_valid), 32'd1);
    chk("beq_we", 32'(EX_we), 32'd0);
    chk("beq_imm", EX_imm, 32'hFFFF_FFFC);
    Instruction_D = enc(6'd8, 4'd0, 4'd1, 4'd2, 14'h3FFC);
    #1;
    chk_ctrl("bne", 1'b0, 1'b0, 2'b00);
    chk("bne_off", PC_offset, 32'd0);
    tick();
    chk("bne_op", 32'(EX_op), 32'd8);

    // J with wrap-around: FFFFFFFE + 5 = 3
    NPC_D = 32'hFFFF_FFFE;
    Instruction_D = {6'd9, 26'd5};
    #1;
    chk_ctrl("j", 1'b0, 1'b1, 2'b01);
    chk("j_off", PC_offset, 32'd3);
    tick();

    // JR R5 with R5=10
    Instruction_D = 32'd0;
    wb(1'b1, 4'd5, 32'd10);
    tick();
    wb(1'b0, 4'd0, 32'd0);
    Instruction_D = enc(6'd10, 4'd0, 4'd5, 4'd0, 14'd0);
    #1;
    chk_ctrl("jr", 1'b0, 1'b1, 2'b10);
    chk("jr_rrs", PC_regRs, 32'd10);
    chk("jr_off", PC_offset, 32'd0);
    tick();
    Instruction_D = 32'd0;
    #1;
    chk_ctrl("jr_after", 1'b0, 1'b0, 2'b00);
    tick();

    // LW R6 then BEQ R6,R0: 2 stalls, then resolves with WB-written R6=5 (not taken)
    Instruction_D = enc(6'd5, 4'd6, 4'd0, 4'd0, 14'd0);
    tick();
    chk("lw_memrd", 32'(EX_memrd), 32'd1);
    chk("lw_rd", 32'(EX_rd), 32'd6);
    NPC_D = 32'd40;
    Instruction_D = enc(6'd7, 4'd0, 4'd6, 4'd0, 14'd3);
    #1;
    chk_ctrl("dep_s1", 1'b1, 1'b0, 2'b00);
    chk("dep_s1_off", PC_offset, 32'd0);
    tick();
    chk_ctrl("dep_s2", 1'b1, 1'b0, 2'b00);
    tick();
    wb(1'b1, 4'd6, 32'd5);
    #1;
    chk_ctrl("dep_go", 1'b0, 1'b0, 2'b00);
    tick();
    chk("dep_A", EX_A, 32'd5);
    chk("dep_valid", 32'(EX_valid), 32'd1);

    // reset in the middle of a stall
    wb(1'b0, 4'd0, 32'd0);
    Instruction_D = enc(6'd5, 4'd7, 4'd0, 4'd0, 14'd0);
    tick();
    Instruction_D = enc(6'd1, 4'd8, 4'd5, 4'd7, 14'd0);
    #1;
    chk("mid_stall", 32'(disable_PC), 32'd1);
    reset = 1'b1;
    #1;
    chk_ctrl("mid_rst", 1'b0, 1'b0, 2'b00);
    tick();
    reset = 1'b0;
    #1;
    chk_ctrl("post_rst", 1'b0, 1'b0, 2'b00);
    chk("post_rst_valid", 32'(EX_valid), 32'd0);
    tick();
    chk("post_valid", 32'(EX_valid), 32'd1);
    chk("post_A", EX_A, 32'd0);
    chk("post_rd", 32'(EX_rd), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_decode_hazard.md
# id_decode_hazard

Decode-stage control block of the 5-stage pipeline. It consumes `Instruction_D` and `NPC_D` from the IF/ID buffer and reads operands from a 16×32 register file with WB write-through. It resolves branches, jumps and JR in ID and drives the IF-stage controls `disable_PC`, `disable_IR`, `KILL`, `PCsrc`, `PC_offset` and `PC_regRs`. It also holds the ID/EX pipeline register and a 2-deep destination scoreboard for RAW stall detection.

## Interface
Parameters:
- `NOP_OP`, default 6'd0: opcode treated as a harmless ALU op. An all-zero word is NOP (AND R0,R0,R0).

Ports:
- `clk`: in, 1. Rising-edge clock.
- `reset`: in, 1. Synchronous, active-high.
- `Instruction_D`: in, 32. From IF/ID.
- `NPC_D`: in, 32. PC+1 of the ID instruction (word-addressed).
- `WB_we`: in, 1. WB register-file write enable.
- `WB_rd`: in, 4. WB destination register.
- `WB_data`: in, 32. WB write data.
- `disable_PC`: out, 1. Stall PC.
- `disable_IR`: out, 1. Stall IF/ID.
- `KILL`: out, 1. Squash the instruction entering IF/ID.
- `PCsrc`: out, 2. 00 selects NPC, 01 selects `PC_offset`, 10 selects `PC_regRs`.
- `PC_offset`: out, 32. Branch or jump target.
- `PC_regRs`: out, 32. JR target.
- `EX_valid`, `EX_we`, `EX_memrd`, `EX_memwr`: out, 1 each. ID/EX control.
- `EX_op`: out, 6. ID/EX opcode.
- `EX_rd`: out, 4. ID/EX destination register.
- `EX_A`, `EX_B`, `EX_imm`: out, 32 each. ID/EX operands and sign-extended immediate.

## Operation
- Instruction fields:
  - op[31:26], rd[25:22], rs[21:18], rt[17:14], imm14[13:0].
  - J uses off26[25:0].
- Opcode table:
  - 0 AND, 1 ADD, 2 SUB: read rs, rt; write rd.
  - 3 ADDI, 4 ANDI: read rs; write rd.
  - 5 LW: read rs; write rd; memrd.
  - 6 SW: read rs, rt; memwr.
  - 7 BEQ, 8 BNE: read rs, rt.
  - 9 J: no reads.
  - 10 JR: read rs.
  - 11–63: decode as NOP, with no read, write or memory access.
- A write to R0 is never performed. R0 always reads 0, and `EX_we` is 0 when rd=0.
- Register file:
  - Written at posedge when `WB_we` is set.
  - A read of the register being written in the same cycle returns `WB_data` combinationally (write-through).
- Scoreboard: entries SB_EX and SB_MEM, each holding {we, rd}.
  - Each cycle SB_MEM <= SB_EX, and SB_EX <= the {we, rd} issued into ID/EX (0 on a bubble).
- Stall: asserted when a source the instruction actually reads (rs and/or rt, nonzero) equals a valid rd in SB_EX or SB_MEM.
  - A dependency in SB_EX stalls for 2 cycles; one in SB_MEM stalls for 1 cycle.
  - WB-stage producers are covered by write-through and never stall.
- While stalled:
  - `disable_PC` = `disable_IR` = 1.
  - `KILL` = 0 and `PCsrc` = 00. No redirect is made using stale operands.
  - ID/EX loads a bubble: all `EX_*` = 0.
- When not stalled:
  - ID/EX loads the decoded instruction with `EX_valid` = 1.
  - `EX_A` = R[rs], `EX_B` = R[rt], `EX_imm` = sext(imm14).
- Redirects (issued only when not stalled):
  - BEQ taken when R[rs] == R[rt]; BNE taken when R[rs] != R[rt].
  - Taken branch: `PCsrc` = 01, `PC_offset` = `NPC_D` + sext(imm14), `KILL` = 1.
  - J: `PCsrc` = 01, `PC_offset` = `NPC_D` + sext(off26), `KILL` = 1.
  - JR: `PCsrc` = 10, `PC_regRs` = R[rs], `KILL` = 1.
  - Not-taken branch: `PCsrc` = 00, `KILL` = 0. The branch itself still enters ID/EX as a non-writing op.
- All address arithmetic is 32-bit modulo 2^32. Wrap-around is silent.

## Timing
- `disable_PC`, `disable_IR`, `KILL`, `PCsrc`, `PC_offset` and `PC_regRs` are combinational from the ID instruction, the register file and the scoreboard, and are valid in the same cycle.
- When `PC_offset` and `PC_regRs` are not selected, they are 0.
- ID/EX and the scoreboard update at posedge, giving 1-cycle latency from ID to `EX_*`.
- Reset (synchronous, takes effect at the posedge with `reset` = 1):
  - All `EX_*` = 0, scoreboard cleared, all 16 registers = 0.
  - During reset the combinational outputs are forced to `disable_PC` = `disable_IR` = `KILL` = 0, `PCsrc` = 00, `PC_offset` = `PC_regRs` = 0.
  - Reset in the middle of a stall abandons the stall. The next cycle starts clean.
- Simultaneous events:
  - A WB write and a stall in the same cycle: the write still happens.
  - A WB write to a register an ID instruction with a SB_MEM match depends on: the SB_MEM stall still applies. That WB write is an older producer.
- Stall priority: stall > redirect. A branch that depends on a pending producer waits, then resolves with forwarded-through values.

## Test plan
- **Reset:** hold `reset` for 2 cycles with random `Instruction_D` -> all `EX_*` = 0, `PCsrc` = 00, `KILL` = `disable_PC` = `disable_IR` = 0.
- **Write-through:** with `WB_we` = 1, `WB_rd` = 3, `WB_data` = 5, present ADD R4,R3,R3 in the same cycle -> next cycle `EX_A` = `EX_B` = 5, `EX_rd` = 4, `EX_we` = 1, no stall.
- **RAW stall:** issue ADDI R1,R0,#9, then ADD R2,R1,R1 -> `disable_PC` = `disable_IR` = 1 for exactly 2 cycles with 2 bubbles in ID/EX. The ADD then issues with `EX_A` = 9 once WB writes R1 = 9.
- **BEQ taken:** R1 = R2 = 7, `NPC_D` = 20, imm14 = −4 -> same cycle `PCsrc` = 01, `PC_offset` = 16, `KILL` = 1. BNE with the same operands -> `PCsrc` = 00, `KILL` = 0.
- **JR:** R5 = 10, then JR R5 -> `PCsrc` = 10, `PC_regRs` = 10, `KILL` = 1 for 1 cycle.
- **Dependent branch:** LW R6, then BEQ R6,R0 -> 2 stall cycles with `KILL` = 0 and `PCsrc` = 00. The branch then resolves using the WB-written R6.
